map_write_arbiter: RTL and testbench
====================================

MAP_WRITE_ARBITER -- requirements
Module: map_write_arbiter

Interface
REQ-001 SHALL have parameter BLANK_CODE, default 4'd0: tile code written when erasing an old location.
REQ-002 SHALL have parameter NREQ, default 3, fixed: requester 0 is the pacman location controller; requesters 1 and 2 are ghost controllers.
REQ-003 SHALL have port CLOCK_50  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port req  input  [2:0]: per-requester move request, level-held until that requester's done.
REQ-006 SHALL have ports curr_x0/1/2  input  [5:0] and curr_y0/1/2  input  [4:0]: location to erase, per requester.
REQ-007 SHALL have ports next_x0/1/2  input  [5:0] and next_y0/1/2  input  [4:0]: location to draw, per requester.
REQ-008 SHALL have ports sprite0/1/2  input  [3:0]: tile code to draw at the next location.
REQ-009 SHALL have port video_busy  input  1: high while the map RAM read side must not be disturbed; blocks new grants only.
REQ-010 SHALL have port wr_en  output  1: map RAM write strobe.
REQ-011 SHALL have port wr_addr  output  [10:0]: map RAM address = {y[4:0], x[5:0]}.
REQ-012 SHALL have port wr_data  output  [3:0]: map RAM write data.
REQ-013 SHALL have port done  output  [2:0]: one-cycle completion pulse, one bit per requester.
REQ-014 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> ERASE -> DRAW -> ACK -> IDLE, with one cycle in each of ERASE, DRAW and ACK.
REQ-016 In IDLE with video_busy=0 and any req bit set, SHALL grant one requester, latch its curr, next and sprite into internal registers, and enter ERASE on the next edge.
REQ-017 In IDLE with video_busy=1, SHALL stay in IDLE, grant nothing, and hold wr_en=0.
REQ-018 Arbitration SHALL be round-robin: search starts at the index after the last granted (modulo 3); last-granted resets to 2, so requester 0 wins first.
REQ-019 In ERASE, SHALL drive wr_en=1, wr_addr={latched curr_y, curr_x}, wr_data=BLANK_CODE.
REQ-020 In DRAW, SHALL drive wr_en=1, wr_addr={latched next_y, next_x}, wr_data=latched sprite.
REQ-021 If latched curr equals latched next (wall-blocked move), SHALL still perform both writes in order, so the final tile is the sprite.
REQ-022 In ACK, SHALL drive done[granted]=1 and every other done bit 0; wr_en=0.
REQ-023 Outside ERASE and DRAW, SHALL hold wr_en=0; wr_addr and wr_data are don't-care there.
REQ-024 Latency: with req sampled high in IDLE at edge N, ERASE SHALL occupy cycle N+1, DRAW N+2 and ACK N+3.
REQ-025 Input changes after the grant (req drop, coordinate change) SHALL NOT affect an operation in progress; done SHALL still pulse.
REQ-026 A requester still asserting req in the IDLE after its ACK SHALL be treated as a new request, subject to round-robin.
REQ-027 video_busy rising mid-operation SHALL NOT stall ERASE, DRAW or ACK.
REQ-028 A req bit asserted while busy=1 SHALL be held pending, not lost; it is sampled in the next IDLE.
REQ-029 Coordinates SHALL pass through unmodified, with no range check or wrap; collision legality is the requester's responsibility.

Reset
REQ-030 On reset, SHALL enter IDLE, set last-granted to 2, clear the latched registers, and drive wr_en=0, done=3'b000, busy=0.
REQ-031 Reset asserted mid-operation SHALL abort at the next edge, with no further write and no done pulse.

Verification
REQ-032 Single request: req=001, curr=(20,20), next=(20,19), sprite=4'd3 -> cycle N+1 addr=0x514 (20<<6|20), data=0; N+2 addr=0x4D4, data=3; N+3 done=001.
REQ-033 Contention: req=111 held with immediate re-request -> done order 001, 010, 100, 001; ACK-to-ACK spacing 4 cycles; never two done bits high at once.
REQ-034 video_busy=1 for 10 cycles with req=010 -> wr_en stays 0 and busy stays 0; grant occurs on the first edge after video_busy falls; done=010 three cycles later.
REQ-035 Blocked move, curr=next=(5,7), sprite=2 -> two writes to 0x1C5 (data 0, then 2), then done pulses.
REQ-036 Reset asserted during DRAW -> next cycle wr_en=0, busy=0, no done; a subsequent req=100 is granted normally.
REQ-037 req dropped during ERASE -> DRAW and ACK still occur; done pulses once.

Source files
------------

// File: rtl/map_write_arbiter.sv
// Map write arbiter: serialises tile moves from the pacman controller and two
// ghost controllers onto the single map RAM write port. Each granted move is
// an erase of the old tile followed by a draw of the sprite at the new tile,
// then a one-cycle done pulse back to the winning requester.
module map_write_arbiter #(
  parameter logic [3:0] BLANK_CODE = 4'd0,
  parameter int         NREQ       = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [5:0]  curr_x0,
  input  logic [5:0]  curr_x1,
  input  logic [5:0]  curr_x2,
  input  logic [4:0]  curr_y0,
  input  logic [4:0]  curr_y1,
  input  logic [4:0]  curr_y2,
  input  logic [5:0]  next_x0,
  input  logic [5:0]  next_x1,
  input  logic [5:0]  next_x2,
  input  logic [4:0]  next_y0,
  input  logic [4:0]  next_y1,
  input  logic [4:0]  next_y2,
  input  logic [3:0]  sprite0,
  input  logic [3:0]  sprite1,
  input  logic [3:0]  sprite2,
  input  logic        video_busy,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [3:0]  wr_data,
  output logic [2:0]  done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;   // last granted requester
  logic [1:0]  gnt_q, gnt_d;     // requester owning the operation in flight
  logic [5:0]  cx_q, cx_d;
  logic [4:0]  cy_q, cy_d;
  logic [5:0]  nx_q, nx_d;
  logic [4:0]  ny_q, ny_d;
  logic [3:0]  spr_q, spr_d;

  logic [2:0]  pick;             // {found, index}
  logic [5:0]  sel_cx;
  logic [4:0]  sel_cy;
  logic [5:0]  sel_nx;
  logic [4:0]  sel_ny;
  logic [3:0]  sel_spr;

  // Round-robin search: start one past the last winner, wrap after the
  // highest index, and take the first requester found asserting req.
  function automatic logic [2:0] rr_pick(input logic [2:0] r,
                                         input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res  = 3'b000;
    cand = last;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!res[2] && r[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  // Round-robin candidate and its move parameters, ready to latch on grant.
  always_comb begin
    pick    = rr_pick(req, last_q);
    sel_cx  = curr_x0;
    sel_cy  = curr_y0;
    sel_nx  = next_x0;
    sel_ny  = next_y0;
    sel_spr = sprite0;
    case (pick[1:0])
      2'd1: begin
        sel_cx  = curr_x1;
        sel_cy  = curr_y1;
        sel_nx  = next_x1;
        sel_ny  = next_y1;
        sel_spr = sprite1;
      end
      2'd2: begin
        sel_cx  = curr_x2;
        sel_cy  = curr_y2;
        sel_nx  = next_x2;
        sel_ny  = next_y2;
        sel_spr = sprite2;
      end
      default: begin
        sel_cx  = curr_x0;
        sel_cy  = curr_y0;
        sel_nx  = next_x0;
        sel_ny  = next_y0;
        sel_spr = sprite0;
      end
    endcase
  end

  // Next-state and Moore outputs. Move parameters are captured only at grant,
  // so requester inputs are free to change once ERASE has started.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    spr_d   = spr_q;
    wr_en   = 1'b0;
    wr_addr = 11'd0;
    wr_data = 4'd0;
    done    = 3'b000;
    busy    = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // video_busy only holds off new grants; it never stalls a move.
        if (!video_busy && pick[2]) begin
          state_d = ERASE;
          gnt_d   = pick[1:0];
          last_d  = pick[1:0];
          cx_d    = sel_cx;
          cy_d    = sel_cy;
          nx_d    = sel_nx;
          ny_d    = sel_ny;
          spr_d   = sel_spr;
        end
      end
      ERASE: begin
        wr_en   = 1'b1;
        wr_addr = {cy_q, cx_q};
        wr_data = BLANK_CODE;
        state_d = DRAW;
      end
      DRAW: begin
        // Always after the erase, so a blocked move (curr == next) ends
        // with the sprite on the tile.
        wr_en   = 1'b1;
        wr_addr = {ny_q, nx_q};
        wr_data = spr_q;
        state_d = ACK;
      end
      ACK: begin
        done    = 3'b001 << gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-move registers; reset aborts any move in flight.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      gnt_q   <= 2'd0;
      cx_q    <= 6'd0;
      cy_q    <= 5'd0;
      nx_q    <= 6'd0;
      ny_q    <= 5'd0;
      spr_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      spr_q   <= spr_d;
    end
  end

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter with a cycle-stamped scoreboard of
// expected write/done activity.
module tb_map_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  curr_x0, curr_x1, curr_x2;
  logic [4:0]  curr_y0, curr_y1, curr_y2;
  logic [5:0]  next_x0, next_x1, next_x2;
  logic [4:0]  next_y0, next_y1, next_y2;
  logic [3:0]  sprite0, sprite1, sprite2;
  logic        video_busy;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [3:0]  wr_data;
  logic [2:0]  done;
  logic        busy;

  always #5 clk = ~clk;

  map_write_arbiter #(.BLANK_CODE(4'd0), .NREQ(3)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .req        (req),
    .curr_x0    (curr_x0),
    .curr_x1    (curr_x1),
    .curr_x2    (curr_x2),
    .curr_y0    (curr_y0),
    .curr_y1    (curr_y1),
    .curr_y2    (curr_y2),
    .next_x0    (next_x0),
    .next_x1    (next_x1),
    .next_x2    (next_x2),
    .next_y0    (next_y0),
    .next_y1    (next_y1),
    .next_y2    (next_y2),
    .sprite0    (sprite0),
    .sprite1    (sprite1),
    .sprite2    (sprite2),
    .video_busy (video_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done),
    .busy       (busy)
  );

  typedef struct {
    int         cyc;
    logic       wr_en;
    logic [10:0] addr;
    logic [3:0]  data;
    logic [2:0]  done;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [10:0] addr_of(input logic [5:0] x, input logic [4:0] y);
    return 11'(y) * 11'd64 + 11'(x);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and compare outputs against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      chk($sformatf("wr_en@%0d", cyc), 16'(wr_en), 16'(e.wr_en));
      if (e.wr_en) begin
        chk($sformatf("wr_addr@%0d", cyc), 16'(wr_addr), 16'(e.addr));
        chk($sformatf("wr_data@%0d", cyc), 16'(wr_data), 16'(e.data));
      end
      chk($sformatf("done@%0d", cyc), 16'(done), 16'(e.done));
      chk($sformatf("busy@%0d", cyc), 16'(busy), 16'd1);
    end else begin
      chk($sformatf("idle_wr_en@%0d", cyc), 16'(wr_en), 16'd0);
      chk($sformatf("idle_done@%0d", cyc), 16'(done), 16'd0);
      chk($sformatf("idle_busy@%0d", cyc), 16'(busy), 16'd0);
    end
  endtask

  task automatic push(input int c, input logic we, input logic [10:0] a,
                      input logic [3:0] d, input logic [2:0] dn);
    exp_t e;
    e.cyc = c; e.wr_en = we; e.addr = a; e.data = d; e.done = dn;
    sbq.push_back(e);
  endtask

  // Expected erase/draw/done for a move whose req is first sampled at edge base+1.
  task automatic push_op(input int base, input int idx,
                         input logic [5:0] cx, input logic [4:0] cy,
                         input logic [5:0] nx, input logic [4:0] ny,
                         input logic [3:0] sp);
    push(base + 1, 1'b1, addr_of(cx, cy), 4'd0, 3'b000);
    push(base + 2, 1'b1, addr_of(nx, ny), sp, 3'b000);
    push(base + 3, 1'b0, 11'd0, 4'd0, 3'(1 << idx));
  endtask

  task automatic set_req(input int idx,
                         input logic [5:0] cx, input logic [4:0] cy,
                         input logic [5:0] nx, input logic [4:0] ny,
                         input logic [3:0] sp);
    case (idx)
      0: begin curr_x0 = cx; curr_y0 = cy; next_x0 = nx; next_y0 = ny; sprite0 = sp; end
      1: begin curr_x1 = cx; curr_y1 = cy; next_x1 = nx; next_y1 = ny; sprite1 = sp; end
      default: begin curr_x2 = cx; curr_y2 = cy; next_x2 = nx; next_y2 = ny; sprite2 = sp; end
    endcase
  endtask

  // One isolated move: request held until done, then dropped.
  task automatic run_op(input int idx,
                        input logic [5:0] cx, input logic [4:0] cy,
                        input logic [5:0] nx, input logic [4:0] ny,
                        input logic [3:0] sp);
    set_req(idx, cx, cy, nx, ny, sp);
    req = 3'(1 << idx);
    push_op(cyc, idx, cx, cy, nx, ny, sp);
    repeat (3) step();
    req = 3'b000;
    step();
  endtask

  initial begin
    int c;
    reset = 1'b1; req = 3'b000; video_busy = 1'b0;
    curr_x0 = '0; curr_x1 = '0; curr_x2 = '0;
    curr_y0 = '0; curr_y1 = '0; curr_y2 = '0;
    next_x0 = '0; next_x1 = '0; next_x2 = '0;
    next_y0 = '0; next_y1 = '0; next_y2 = '0;
    sprite0 = '0; sprite1 = '0; sprite2 = '0;

    // Reset state
    step(); step();
    chk("rst_wr_en", 16'(wr_en), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    step();

    // Single request from pacman: erase (20,20), draw sprite 3 at (20,19)
    set_req(0, 6'd20, 5'd20, 6'd20, 5'd19, 4'd3);
    req = 3'b001;
    push_op(cyc, 0, 6'd20, 5'd20, 6'd20, 5'd19, 4'd3);
    step();
    chk("single_erase_addr", 16'(wr_addr), 16'h514);
    step();
    chk("single_draw_addr", 16'(wr_addr), 16'h4D4);
    chk("single_draw_data", 16'(wr_data), 16'd3);
    step();
    chk("single_done", 16'(done), 16'b001);
    req = 3'b000;
    step(); step();

    // video_busy holds off the grant; rising again mid-move does not stall it
    set_req(1, 6'd10, 5'd3, 6'd11, 5'd3, 4'd6);
    video_busy = 1'b1;
    req = 3'b010;
    repeat (10) step();
    video_busy = 1'b0;
    push_op(cyc, 1, 6'd10, 5'd3, 6'd11, 5'd3, 4'd6);
    step();
    video_busy = 1'b1;
    step(); step();
    req = 3'b000;
    step();
    video_busy = 1'b0;
    step();

    // Blocked move: same tile erased then drawn
    run_op(0, 6'd5, 5'd7, 6'd5, 5'd7, 4'd2);
    step();

    // Contention after reset: 0, 1, 2, 0 with immediate re-requests
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 6'd1, 5'd1, 6'd2, 5'd1, 4'd4);
    set_req(1, 6'd30, 5'd15, 6'd30, 5'd16, 4'd8);
    set_req(2, 6'd63, 5'd31, 6'd62, 5'd31, 4'd9);
    req = 3'b111;
    c = cyc;
    push_op(c,      0, 6'd1,  5'd1,  6'd2,  5'd1,  4'd4);
    push_op(c + 4,  1, 6'd30, 5'd15, 6'd30, 5'd16, 4'd8);
    push_op(c + 8,  2, 6'd63, 5'd31, 6'd62, 5'd31, 4'd9);
    push_op(c + 12, 0, 6'd1,  5'd1,  6'd2,  5'd1,  4'd4);
    repeat (13) step();
    req = 3'b000;
    repeat (5) step();

    // Reset during DRAW aborts the move with no done
    set_req(0, 6'd8, 5'd8, 6'd9, 5'd8, 4'd5);
    req = 3'b001;
    c = cyc;
    push(c + 1, 1'b1, addr_of(6'd8, 5'd8), 4'd0, 3'b000);
    push(c + 2, 1'b1, addr_of(6'd9, 5'd8), 4'd5, 3'b000);
    step(); step();
    reset = 1'b1;
    req = 3'b000;
    step();
    chk("abort_wr_en", 16'(wr_en), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    reset = 1'b0;
    step(); step();
    run_op(2, 6'd40, 5'd20, 6'd41, 5'd20, 4'd7);

    // req dropped and coordinates changed during ERASE
    set_req(1, 6'd12, 5'd9, 6'd12, 5'd10, 4'd1);
    req = 3'b010;
    push_op(cyc, 1, 6'd12, 5'd9, 6'd12, 5'd10, 4'd1);
    step();
    req = 3'b000;
    set_req(1, 6'd0, 5'd0, 6'd33, 5'd22, 4'd15);
    repeat (6) step();

    chk("scoreboard_drained", 16'(sbq.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
